memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter_if.sv | 31 +++
 rtl/memory_arbiter.sv | 112 +++++++++++
 tb/tb_memory_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// Cache/RAM bus bundle for the memory arbiter: icache and dcache request ports plus the RAM port.
interface memory_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    // Arbiter side
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    // Caches and RAM side
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates a single RAM port between icache and dcache; dcache has priority
// unless the icache has been passed over STARVE_MAX consecutive times.
module memory_arbiter #(
    parameter int unsigned STARVE_MAX = 7
) (
    input  logic                  CLK,
    input  logic                  nRST,
    memory_arbiter_if.slave       bus,
    output logic                  memerr,
    output logic [2:0]            starve_ct
);

    localparam int unsigned CT_W = 3;
    localparam logic [CT_W-1:0] STARVE_LIM = CT_W'(STARVE_MAX);
    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DSERV = 2'd1,
        ISERV = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              memerr_q, memerr_d;
    logic [CT_W-1:0]   starve_q, starve_d;

    logic ram_done;
    logic ram_err;
    logic d_req;
    logic i_starved;

    assign ram_done  = (bus.ramstate == RAM_ACCESS) || (bus.ramstate == RAM_ERROR);
    assign ram_err   = (bus.ramstate == RAM_ERROR);
    assign d_req     = bus.dREN | bus.dWEN;
    assign i_starved = bus.iREN && (starve_q == STARVE_LIM);

    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;
    assign memerr    = memerr_q;
    assign starve_ct = starve_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            memerr_q <= 1'b0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            memerr_q <= memerr_d;
            starve_q <= starve_d;
        end
    end

    // Next state, RAM steering and stall generation; FREE/BUSY simply hold.
    always_comb begin
        state_d      = state_q;
        memerr_d     = memerr_q;
        starve_d     = starve_q;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;

        case (state_q)
            IDLE: begin
                if (d_req && !i_starved) begin
                    state_d = DSERV;
                end else if (bus.iREN) begin
                    state_d = ISERV;
                end
            end

            DSERV: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                if (!d_req) begin
                    state_d = IDLE;
                end else if (ram_done) begin
                    bus.dwait = 1'b0;
                    state_d   = IDLE;
                    memerr_d  = memerr_q | ram_err;
                    if (!bus.iREN) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_LIM) begin
                        starve_d = starve_q + CT_W'(1);
                    end
                end
            end

            ISERV: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = bus.iREN;
                if (!bus.iREN) begin
                    state_d = IDLE;
                end else if (ram_done) begin
                    bus.iwait = 1'b0;
                    state_d   = IDLE;
                    memerr_d  = memerr_q | ram_err;
                    starve_d  = '0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: cycle vector table through a scoreboard queue,
// plus a hand-written mid-transaction reset sequence.
module tb_memory_arbiter;

    localparam logic [1:0] F = 2'd0;
    localparam logic [1:0] B = 2'd1;
    localparam logic [1:0] A = 2'd2;
    localparam logic [1:0] E = 2'd3;

    typedef struct {
        logic        iren, dren, dwen;
        logic [1:0]  rs;
        logic [31:0] iaddr, daddr, dstore, ramload;
        logic        eren, ewen;
        logic [31:0] eaddr, estore;
        logic        edw, eiw;
        logic [2:0]  est;
        logic        eme;
    } vec_t;

    logic       CLK;
    logic       nRST;
    logic       memerr;
    logic [2:0] starve_ct;

    memory_arbiter_if bus();

    memory_arbiter #(.STARVE_MAX(7)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (bus.slave),
        .memerr    (memerr),
        .starve_ct (starve_ct)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic add(input logic iren, dren, dwen, input logic [1:0] rs,
                       input logic [31:0] iaddr, daddr, dstore,
                       input logic eren, ewen, input logic [31:0] eaddr, estore,
                       input logic edw, eiw, input logic [2:0] est, input logic eme);
        vec_t v;
        v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs;
        v.iaddr = iaddr; v.daddr = daddr; v.dstore = dstore;
        v.ramload = 32'h5A00_0000 ^ 32'(vecs.size());
        v.eren = eren; v.ewen = ewen; v.eaddr = eaddr; v.estore = estore;
        v.edw = edw; v.eiw = eiw; v.est = est; v.eme = eme;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        bus.iREN     = v.iren;
        bus.dREN     = v.dren;
        bus.dWEN     = v.dwen;
        bus.ramstate = v.rs;
        bus.iaddr    = v.iaddr;
        bus.daddr    = v.daddr;
        bus.dstore   = v.dstore;
        bus.ramload  = v.ramload;
    endtask

    task automatic check_out(input int idx);
        vec_t e;
        string s;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        s = $sformatf("row%0d", idx);
        chk({s, "_ramREN"},   32'(bus.ramREN),  32'(e.eren));
        chk({s, "_ramWEN"},   32'(bus.ramWEN),  32'(e.ewen));
        chk({s, "_ramaddr"},  bus.ramaddr,      e.eaddr);
        chk({s, "_ramstore"}, bus.ramstore,     e.estore);
        chk({s, "_dwait"},    32'(bus.dwait),   32'(e.edw));
        chk({s, "_iwait"},    32'(bus.iwait),   32'(e.eiw));
        chk({s, "_starve"},   32'(starve_ct),   32'(e.est));
        chk({s, "_memerr"},   32'(memerr),      32'(e.eme));
        chk({s, "_dload"},    bus.dload,        e.ramload);
        chk({s, "_iload"},    bus.iload,        e.ramload);
        chk({s, "_one_grant"}, 32'(bus.iwait | bus.dwait), 32'd1);
        chk({s, "_ren_wen"},  32'(bus.ramREN & bus.ramWEN), 32'd0);
    endtask

    initial begin
        nRST = 1'b0;
        drive('{default: '0});
        #12;
        chk("rst_iwait",  32'(bus.iwait),  32'd1);
        chk("rst_dwait",  32'(bus.dwait),  32'd1);
        chk("rst_ramREN", 32'(bus.ramREN), 32'd0);
        chk("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
        chk("rst_memerr", 32'(memerr),     32'd0);
        chk("rst_starve", 32'(starve_ct),  32'd0);

        // Read with two BUSY cycles
        add(0,1,0,F, 0,32'h100,0, 0,0,0,0,1,1,0,0);
        add(0,1,0,B, 0,32'h100,0, 1,0,32'h100,0,1,1,0,0);
        add(0,1,0,B, 0,32'h100,0, 1,0,32'h100,0,1,1,0,0);
        add(0,1,0,A, 0,32'h100,0, 1,0,32'h100,0,0,1,0,0);
        add(0,0,0,F, 0,32'h100,0, 0,0,0,0,1,1,0,0);
        // Write wins over read when both set
        add(0,1,1,F, 0,32'h200,32'hDEADBEEF, 0,0,0,0,1,1,0,0);
        add(0,1,1,A, 0,32'h200,32'hDEADBEEF, 0,1,32'h200,32'hDEADBEEF,0,1,0,0);
        add(0,0,0,F, 0,0,0, 0,0,0,0,1,1,0,0);
        // Starvation: seven dcache grants, then the icache
        for (int g = 0; g < 7; g++) begin
            add(1,1,0,A, 32'h40,32'h300,32'hCAFEF00D, 0,0,0,0,1,1,3'(g),0);
            add(1,1,0,A, 32'h40,32'h300,32'hCAFEF00D, 1,0,32'h300,32'hCAFEF00D,0,1,3'(g),0);
        end
        add(1,1,0,A, 32'h40,32'h300,32'hCAFEF00D, 0,0,0,0,1,1,7,0);
        add(1,1,0,A, 32'h40,32'h300,32'hCAFEF00D, 1,0,32'h40,0,1,0,7,0);
        add(0,0,0,F, 32'h40,32'h300,0, 0,0,0,0,1,1,0,0);
        // Abandoned dcache read keeps starve count
        add(1,1,0,A, 32'h40,32'h300,0, 0,0,0,0,1,1,0,0);
        add(1,1,0,A, 32'h40,32'h300,0, 1,0,32'h300,0,0,1,0,0);
        add(1,1,0,F, 32'h40,32'h300,0, 0,0,0,0,1,1,1,0);
        add(1,1,0,B, 32'h40,32'h300,0, 1,0,32'h300,0,1,1,1,0);
        add(1,0,0,B, 32'h40,32'h300,0, 0,0,32'h300,0,1,1,1,0);
        add(0,0,0,A, 32'h40,32'h300,0, 0,0,0,0,1,1,1,0);
        // RAM error during icache service; memerr sticks
        add(1,0,0,F, 32'h40,0,0, 0,0,0,0,1,1,1,0);
        add(1,0,0,E, 32'h40,0,0, 1,0,32'h40,0,1,0,1,0);
        add(0,0,0,F, 32'h40,0,0, 0,0,0,0,1,1,0,1);
        add(0,1,0,B, 0,32'h500,0, 0,0,0,0,1,1,0,1);
        add(0,1,0,B, 0,32'h500,0, 1,0,32'h500,0,1,1,0,1);
        add(0,1,0,A, 0,32'h500,0, 1,0,32'h500,0,0,1,0,1);
        add(0,0,0,F, 0,0,0, 0,0,0,0,1,1,0,1);

        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            exp_q.push_back(vecs[i]);
            @(negedge CLK);
            check_out(i);
            @(posedge CLK); #1;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        // Reset pulsed in the middle of a dcache read
        bus.dREN = 1'b1; bus.dWEN = 1'b0; bus.iREN = 1'b0;
        bus.daddr = 32'h400; bus.ramstate = F;
        @(posedge CLK); #1;
        bus.ramstate = B;
        @(negedge CLK);
        chk("mid_ramREN",  32'(bus.ramREN), 32'd1);
        chk("mid_ramaddr", bus.ramaddr,     32'h400);
        chk("mid_memerr",  32'(memerr),     32'd1);
        nRST = 1'b0;
        #1;
        chk("rstd_dwait",   32'(bus.dwait),   32'd1);
        chk("rstd_ramREN",  32'(bus.ramREN),  32'd0);
        chk("rstd_ramaddr", bus.ramaddr,      32'h0);
        chk("rstd_memerr",  32'(memerr),      32'd0);
        chk("rstd_starve",  32'(starve_ct),   32'd0);
        bus.ramstate = A;
        @(posedge CLK); #1;
        chk("rsth_dwait",  32'(bus.dwait),  32'd1);
        chk("rsth_ramREN", 32'(bus.ramREN), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk("rel_ramREN", 32'(bus.ramREN), 32'd0);
        @(posedge CLK); #1;
        chk("grant_ramREN",  32'(bus.ramREN), 32'd1);
        chk("grant_ramaddr", bus.ramaddr,     32'h400);
        chk("grant_dwait",   32'(bus.dwait),  32'd0);
        @(posedge CLK); #1;
        bus.dREN = 1'b0;
        chk("post_dwait",  32'(bus.dwait),  32'd1);
        chk("post_ramREN", 32'(bus.ramREN), 32'd0);
        @(posedge CLK); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
